ldpc_3gpp_dec_syndrome_chk: RTL
===============================

Name: ldpc_3gpp_dec_syndrome_chk

Overview:
Decoder-side counterpart of the encoder parity stage. It checks received hard decisions against the parity equations.
- Input: a stream of cyclically shifted zc-wide hard-decision words, one base-graph term per beat.
- Per check row: XORs the terms to form the row syndrome, masks it to the used expansion factor, and counts nonzero syndrome bits and unsatisfied rows.
- Output: at end of frame, a pass/fail verdict plus error statistics.
- Position: after the decoder iteration core. Used for early termination and decode-status reporting.

Parameters:
pDAT_W, 8, datapath word width. Must be ≥ maximum used zc.
pROW_W, 6, width of the unsatisfied-row counter. Default covers 46 rows of BG1.
pERR_W, 16, width of the unsatisfied-bit counter.

Ports:
iclk  in  1  clock
ireset  in  1  synchronous active-high reset
iclkena  in  1  clock enable. Low freezes all state and outputs.
iused_zc  in  hb_zc_t  used expansion factor. Stable for the whole frame.
ival  in  1  input beat valid
istrb  in  4  beat strobes: [0] sof, [1] sop (first term of row), [2] eop (last term of row), [3] eof (last beat of frame)
idat  in  pDAT_W  shifted hard-decision term. Bit k is the parity contribution to row bit k.
odone  out  1  one-cycle pulse: frame result valid
ook  out  1  1 = all rows satisfied. Held until the next odone.
orow_err  out  pROW_W  number of rows with a nonzero masked syndrome. Held.
obit_err  out  pERR_W  total nonzero syndrome bits in the frame. Held.

Behaviour:
- Reset values: odone=0, ook=0, orow_err=0, obit_err=0. Accumulator, pipeline valids and frame counters are all cleared.
- Reset asserted mid-frame aborts the frame; no odone is produced for it.
- All state advances only when iclkena=1. Beats with ival=0 are ignored.

Stage A, row accumulator:
- On a valid beat: acc <= sop ? idat : acc ^ idat.
- If eop: row word = (sop ? idat : acc ^ idat) & mask, registered into stage B with row_val=1. mask = low iused_zc bits set.
- A beat carrying both sop and eop is a single-term row.
- eof without eop is treated as eop (the row closes).
- sof clears the frame counters in stage C at the point where that beat's row result reaches stage C; counting restarts from zero.

Stage B:
- popcount of the masked row word, width clog2(pDAT_W+1).
- Registered with nz = (word != 0).
- The row_val and eof flags travel alongside.

Stage C, frame counters:
- On row_val: row_cnt += nz and bit_cnt += popcount. Both saturate at all-ones.
- If the eof flag is set, the same cycle's update goes directly to the outputs:
  - orow_err = final row_cnt
  - obit_err = final bit_cnt
  - ook = (final row_cnt == 0)
  - odone pulses
  - internal counters cleared

Latency:
- odone is high in the cycle after the third iclkena edge following the eof beat (eof sampled at edge 0; stage B at edge 1; stage C at edge 2; outputs registered at edge 3).
- Fully pipelined: back-to-back frames with no idle beats are legal. The next frame's sof may immediately follow the previous eof.
- No backpressure: the block always accepts.

Test Plan:
- pDAT_W=8, zc=8, 46 rows, every term 0x00 → odone 3 edges after eof; ook=1, orow_err=0, obit_err=0.
- Row 5 gets the single term 0x01, all other rows zero → ook=0, orow_err=1, obit_err=1.
- zc=4, one row with terms 0xF0 and 0x03 → masked syndrome 0x3; ook=0, orow_err=1, obit_err=2. Repeat with 0xF0 alone → ook=1.
- Two frames back-to-back: frame 1 gives obit_err=3; frame 2 is all-zero → two odone pulses with correct independent results and no carry-over.
- iclkena toggled 0/1 every cycle during a frame → results identical to the ungated run; odone occurs after 3 enabled edges.
- ireset asserted mid-frame, then a clean all-zero frame → no odone for the aborted frame; the next frame reports ook=1 with zero counts.

Source files
------------

// File: rtl/ldpc_3gpp_dec_syndrome_chk.sv
// rtl/ldpc_3gpp_dec_syndrome_chk.sv - LDPC decoder syndrome checker with per-frame error statistics
module ldpc_3gpp_dec_syndrome_chk #(
  parameter int pDAT_W = 8,
  parameter int pROW_W = 6,
  parameter int pERR_W = 16,
  parameter int pZC_W  = 9
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [pZC_W-1:0]  iused_zc,
  input  logic              ival,
  input  logic [3:0]        istrb,
  input  logic [pDAT_W-1:0] idat,
  output logic              odone,
  output logic              ook,
  output logic [pROW_W-1:0] orow_err,
  output logic [pERR_W-1:0] obit_err
);

  localparam int pPOP_W = $clog2(pDAT_W + 1);

  // strobe decode: [0] sof, [1] sop, [2] eop, [3] eof
  logic sof, sop, eop, eof, row_close;
  assign sof       = istrb[0];
  assign sop       = istrb[1];
  assign eop       = istrb[2];
  assign eof       = istrb[3];
  assign row_close = eop | eof;

  // stage A state
  logic [pDAT_W-1:0] acc;
  logic [pDAT_W-1:0] a_word;
  logic              a_val, a_eof, a_sof;
  logic              sof_pend;

  // stage B state
  logic [pPOP_W-1:0] b_pop;
  logic              b_nz, b_val, b_eof, b_sof;

  // stage C state
  logic [pROW_W-1:0] row_cnt, fin_row;
  logic [pERR_W-1:0] bit_cnt, fin_bit;
  logic              fin;

  // combinational helpers
  logic [pDAT_W-1:0] mask;
  logic [pDAT_W-1:0] term_sum;
  logic [pPOP_W-1:0] pop;
  logic [pROW_W-1:0] row_base, row_nxt;
  logic [pERR_W-1:0] bit_base, bit_nxt;
  logic [pERR_W:0]   bit_sum;

  // mask keeps only the low iused_zc syndrome bits
  always_comb begin
    mask = '0;
    for (int k = 0; k < pDAT_W; k++) begin
      mask[k] = (k < int'(iused_zc));
    end
  end

  assign term_sum = sop ? idat : (acc ^ idat);

  // stage A: XOR-accumulate the terms of a row, emit masked syndrome on row close
  always_ff @(posedge iclk) begin
    if (ireset) begin
      acc      <= '0;
      a_word   <= '0;
      a_val    <= 1'b0;
      a_eof    <= 1'b0;
      a_sof    <= 1'b0;
      sof_pend <= 1'b0;
    end else if (iclkena) begin
      a_val <= 1'b0;
      if (ival) begin
        acc <= term_sum;
        if (row_close) begin
          a_word   <= term_sum & mask;
          a_val    <= 1'b1;
          a_eof    <= eof;
          a_sof    <= sof | sof_pend;
          sof_pend <= 1'b0;
        end else if (sof) begin
          // sof arrived mid-row; remember it until the row closes
          sof_pend <= 1'b1;
        end
      end
    end
  end

  // population count of the registered row syndrome
  always_comb begin
    pop = '0;
    for (int i = 0; i < pDAT_W; i++) begin
      pop = pop + pPOP_W'(a_word[i]);
    end
  end

  // stage B: register popcount and nonzero flag with the row flags
  always_ff @(posedge iclk) begin
    if (ireset) begin
      b_pop <= '0;
      b_nz  <= 1'b0;
      b_val <= 1'b0;
      b_eof <= 1'b0;
      b_sof <= 1'b0;
    end else if (iclkena) begin
      b_pop <= pop;
      b_nz  <= (a_word != '0);
      b_val <= a_val;
      b_eof <= a_eof;
      b_sof <= a_sof;
    end
  end

  // saturating counter update; sof restarts counting from zero
  always_comb begin
    row_base = b_sof ? '0 : row_cnt;
    bit_base = b_sof ? '0 : bit_cnt;
    row_nxt  = (row_base == '1) ? row_base : row_base + pROW_W'(b_nz);
    bit_sum  = {1'b0, bit_base} + (pERR_W + 1)'(b_pop);
    bit_nxt  = bit_sum[pERR_W] ? '1 : bit_sum[pERR_W-1:0];
  end

  // stage C: frame counters, snapshot and clear on eof
  always_ff @(posedge iclk) begin
    if (ireset) begin
      row_cnt <= '0;
      bit_cnt <= '0;
      fin_row <= '0;
      fin_bit <= '0;
      fin     <= 1'b0;
    end else if (iclkena) begin
      fin <= 1'b0;
      if (b_val) begin
        if (b_eof) begin
          fin     <= 1'b1;
          fin_row <= row_nxt;
          fin_bit <= bit_nxt;
          row_cnt <= '0;
          bit_cnt <= '0;
        end else begin
          row_cnt <= row_nxt;
          bit_cnt <= bit_nxt;
        end
      end
    end
  end

  // output register: verdict and statistics held until the next frame result
  always_ff @(posedge iclk) begin
    if (ireset) begin
      odone    <= 1'b0;
      ook      <= 1'b0;
      orow_err <= '0;
      obit_err <= '0;
    end else if (iclkena) begin
      odone <= fin;
      if (fin) begin
        ook      <= (fin_row == '0);
        orow_err <= fin_row;
        obit_err <= fin_bit;
      end
    end
  end

endmodule
